// File: rtl/icmp_echo_tx.sv
// ICMP echo-reply transmitter: the first pass over the payload RAM builds the checksum,
// the second pass streams the 8-byte header and then the payload over valid/ready.
`timescale 1ns/1ps
module icmp_echo_tx #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [15:0]       id,
   input  logic [15:0]       seq,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              tx_last,
   output logic              done
);
   typedef enum logic [2:0] {IDLE, SUM, HDR, PAY, DONE} state_t;

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE     = 1;

   state_t          state;
   logic [15:0]     id_reg, seq_reg, sum_reg, csum_reg;
   logic [ADDR_W:0] len_reg, rd_cnt, out_cnt;
   logic [3:0]      hdr_cnt;
   logic            rd_valid, rd_lsb;
   logic [7:0]      buf_data;
   logic            buf_valid;

   function automatic logic [15:0] add1c(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'b0, s[16]};
   endfunction

   logic [ADDR_W:0] len_sat;
   logic [15:0]     hdr_sum, byte_word, sum_next;
   logic            load_ok, pay_issue;
   logic [2:0]      occ;
   logic [7:0]      hdr_byte;

   assign len_sat   = (len > MAX_LEN) ? MAX_LEN : len;
   assign hdr_sum   = add1c(id, seq);
   // Adding high and low bytes as separate words is equivalent to adding the pair.
   assign byte_word = rd_lsb ? {8'h00, mem_data} : {mem_data, 8'h00};
   assign sum_next  = add1c(sum_reg, byte_word);
   assign load_ok   = !tx_valid || tx_ready;
   // Reads in flight plus stored bytes never exceed the two slots (output + skid).
   assign occ       = 3'(mem_rd) + 3'(rd_valid) + 3'(buf_valid) + 3'(tx_valid & ~tx_ready);
   assign pay_issue = (state == PAY) && (rd_cnt < len_reg) && (occ < 3'd2);

   always_comb begin
      hdr_byte = 8'h00;
      case (hdr_cnt[2:0])
         3'd2:    hdr_byte = csum_reg[15:8];
         3'd3:    hdr_byte = csum_reg[7:0];
         3'd4:    hdr_byte = id_reg[15:8];
         3'd5:    hdr_byte = id_reg[7:0];
         3'd6:    hdr_byte = seq_reg[15:8];
         3'd7:    hdr_byte = seq_reg[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         id_reg    <= '0;
         seq_reg   <= '0;
         len_reg   <= '0;
         sum_reg   <= '0;
         csum_reg  <= '0;
         rd_cnt    <= '0;
         out_cnt   <= '0;
         hdr_cnt   <= '0;
         rd_valid  <= 1'b0;
         rd_lsb    <= 1'b0;
         buf_data  <= '0;
         buf_valid <= 1'b0;
         busy      <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         tx_last   <= 1'b0;
         done      <= 1'b0;
      end else begin
         rd_valid <= mem_rd;
         rd_lsb   <= mem_addr[0];
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  id_reg   <= id;
                  seq_reg  <= seq;
                  len_reg  <= len_sat;
                  sum_reg  <= hdr_sum;
                  busy     <= 1'b1;
                  mem_addr <= '0;
                  hdr_cnt  <= '0;
                  if (len_sat == '0) begin
                     csum_reg <= ~hdr_sum;
                     state    <= HDR;
                  end else begin
                     mem_rd <= 1'b1;
                     rd_cnt <= ONE;
                     state  <= SUM;
                  end
               end
            end
            SUM: begin
               if (rd_cnt < len_reg) begin
                  mem_rd   <= 1'b1;
                  mem_addr <= rd_cnt[ADDR_W-1:0];
                  rd_cnt   <= rd_cnt + ONE;
               end else begin
                  mem_rd <= 1'b0;
               end
               if (rd_valid) begin
                  sum_reg <= sum_next;
                  if (!mem_rd) begin
                     csum_reg <= ~sum_next;
                     state    <= HDR;
                  end
               end
            end
            HDR: begin
               if (load_ok) begin
                  if (hdr_cnt == 4'd8) begin
                     tx_valid <= 1'b0;
                     tx_last  <= 1'b0;
                     if (len_reg == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        rd_cnt  <= '0;
                        out_cnt <= '0;
                        state   <= PAY;
                     end
                  end else begin
                     tx_data  <= hdr_byte;
                     tx_valid <= 1'b1;
                     tx_last  <= (hdr_cnt == 4'd7) && (len_reg == '0);
                     hdr_cnt  <= hdr_cnt + 4'd1;
                  end
               end
            end
            PAY: begin
               mem_rd <= pay_issue;
               if (pay_issue) begin
                  mem_addr <= rd_cnt[ADDR_W-1:0];
                  rd_cnt   <= rd_cnt + ONE;
               end
               if (load_ok && tx_valid && tx_last) begin
                  tx_valid <= 1'b0;
                  tx_last  <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else if (load_ok) begin
                  if (buf_valid) begin
                     tx_data   <= buf_data;
                     tx_valid  <= 1'b1;
                     tx_last   <= (out_cnt == len_reg - ONE);
                     out_cnt   <= out_cnt + ONE;
                     buf_data  <= mem_data;
                     buf_valid <= rd_valid;
                  end else if (rd_valid) begin
                     tx_data  <= mem_data;
                     tx_valid <= 1'b1;
                     tx_last  <= (out_cnt == len_reg - ONE);
                     out_cnt  <= out_cnt + ONE;
                  end else begin
                     tx_valid <= 1'b0;
                  end
               end else if (rd_valid) begin
                  buf_data  <= mem_data;
                  buf_valid <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_icmp_echo_tx.sv
// Scoreboard bench for icmp_echo_tx: expected frames are queued at launch and
// compared byte by byte as they leave the stream interface.
`timescale 1ns/1ps
module tb_icmp_echo_tx;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] id = '0, seq = '0;
   logic [8:0]  len = '0;
   logic        busy, mem_rd, tx_valid, tx_last, done;
   logic [7:0]  mem_addr, tx_data;
   logic [7:0]  mem_data = '0;
   logic        tx_ready = 1'b1;

   icmp_echo_tx #(.ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .id(id), .seq(seq), .len(len),
      .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_last(tx_last), .done(done)
   );

   always #5 clk = ~clk;

   logic [7:0] ram [256];
   always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];

   int n_vec = 0, n_err = 0;
   logic [8:0] exp_q [$];
   int frame_bytes = 0, rd_cycles = 0, done_cnt = 0, cur_len = 0;
   bit stall_en = 0, rand_en = 0, st_a = 0, st_b = 0;
   int stall_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] csum_model(input logic [15:0] i, input logic [15:0] s, input int n);
      int unsigned acc = i + s;
      for (int k = 0; k < n; k++)
         acc += (k % 2 == 0) ? (int'(ram[k]) << 8) : int'(ram[k]);
      while (acc > 32'hFFFF) acc = (acc & 32'hFFFF) + (acc >> 16);
      return ~acc[15:0];
   endfunction

   // Output monitor: scoreboard pop, stall stability, read-address bound, done count.
   initial begin
      logic       prev_stall = 0;
      logic [7:0] prev_data = '0;
      logic       prev_last = 0;
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) prev_stall = 0;
         if (prev_stall) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, prev_data);
            check("hold_last", tx_last, prev_last);
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_last  = tx_last;
         if (mem_rd) begin
            rd_cycles++;
            check("addr_lt_len", 32'(mem_addr) < cur_len, 1);
         end
         if (done) begin
            done_cnt++;
            check("busy_at_done", busy, 1);
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", tx_data, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("tx_data", tx_data, e[7:0]);
               check("tx_last", tx_last, e[8]);
            end
            $display("byte %0d: data %02h last %0b", frame_bytes, tx_data, tx_last);
            frame_bytes++;
         end
      end
   end

   // Downstream ready: fixed, random, or with 5-cycle stalls at bytes 3 and 10.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stall_cnt > 0) begin
            tx_ready = 0;
            stall_cnt--;
         end else if (stall_en && tx_valid && frame_bytes == 2 && !st_a) begin
            st_a = 1; stall_cnt = 4; tx_ready = 0;
         end else if (stall_en && tx_valid && frame_bytes == 9 && !st_b) begin
            st_b = 1; stall_cnt = 4; tx_ready = 0;
         end else begin
            tx_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   task automatic launch(input logic [15:0] i, input logic [15:0] s, input int l);
      int n = (l > 256) ? 256 : l;
      logic [15:0] cs = csum_model(i, s, n);
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, cs[15:8]});
      exp_q.push_back({1'b0, cs[7:0]});
      exp_q.push_back({1'b0, i[15:8]});
      exp_q.push_back({1'b0, i[7:0]});
      exp_q.push_back({1'b0, s[15:8]});
      exp_q.push_back({n == 0, s[7:0]});
      for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, ram[k]});
      frame_bytes = 0; rd_cycles = 0; cur_len = n; st_a = 0; st_b = 0;
      @(posedge clk); #1;
      start = 1; id = i; seq = s; len = 9'(l);
      @(posedge clk); #1;
      start = 0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input int n_rd);
      int base = done_cnt;
      int c = 0;
      while (done_cnt == base && c < 3000) begin
         @(posedge clk);
         c++;
      end
      #1;
      check("done_seen", 32'(done_cnt - base), 1);
      check("busy_after_done", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check("single_done", 32'(done_cnt - base), 1);
      check("queue_empty", 32'(exp_q.size()), 0);
      check("rd_count", 32'(rd_cycles), 32'(n_rd));
   endtask

   task automatic load_abcd();
      ram[0] = 8'h61; ram[1] = 8'h62; ram[2] = 8'h63; ram[3] = 8'h64;
   endtask

   initial begin
      for (int k = 0; k < 256; k++) ram[k] = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", tx_valid, 0);
      check("rst_done", done, 0);
      check("rst_mem_rd", mem_rd, 0);
      rst_n = 1;

      // basic frame, expected checksum 0x2904
      load_abcd();
      launch(16'h1234, 16'h0001, 4);
      wait_done(8);

      // empty payload, checksum 0x0000
      launch(16'hFFFF, 16'hFFFF, 0);
      wait_done(0);

      // odd length, checksum 0xFBFD
      ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03;
      launch(16'h0000, 16'h0000, 3);
      wait_done(6);

      // backpressure: stalls at bytes 3 and 10 plus random toggling
      load_abcd();
      stall_en = 1; rand_en = 1;
      launch(16'h1234, 16'h0001, 4);
      wait_done(8);
      stall_en = 0;

      // oversize length saturates to 256 under random backpressure
      for (int k = 0; k < 256; k++) ram[k] = 8'($urandom);
      launch(16'hBEEF, 16'h0102, 300);
      wait_done(512);
      rand_en = 0;

      // start while busy is ignored
      load_abcd();
      launch(16'h1234, 16'h0001, 4);
      repeat (8) @(posedge clk);
      #1; start = 1; id = 16'hAAAA;
      @(posedge clk); #1; start = 0;
      wait_done(8);

      // reset during payload, then a clean frame
      launch(16'h1234, 16'h0001, 4);
      for (int c = 0; c < 500 && frame_bytes < 9; c++) @(posedge clk);
      check("reach_pay", frame_bytes >= 9, 1);
      #2; rst_n = 0;
      @(posedge clk); #1;
      check("rst_mid_valid", tx_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      exp_q.delete();
      rst_n = 1;
      launch(16'h1234, 16'h0001, 4);
      wait_done(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
